// File: rtl/ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StErr    = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ClsLoad,
        ClsStore,
        ClsIalu,
        ClsBeq,
        ClsRalu
    } cls_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpIalu  = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpRalu  = 7'b0110011;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluBranch = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

    function automatic logic isMemCls(cls_e cls);
        return (cls == ClsLoad) || (cls == ClsStore);
    endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Control-unit bundle: run/opcode/memory-ready inputs and the datapath control outputs.
interface ctrl_fsm_if;
    logic       run_i;
    logic [6:0] op_i;
    logic       noop_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       ir_write_o;
    logic [1:0] alu_op_o;
    logic       alu_src_o;
    logic       reg_write_o;
    logic       mem_to_reg_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       branch_o;
    logic       retire_o;
    logic       busy_o;
    logic       err_o;
    logic [2:0] state_o;

    modport master (
        input  run_i, op_i, noop_i, mem_ready_i,
        output pc_write_o, ir_write_o, alu_op_o, alu_src_o, reg_write_o, mem_to_reg_o,
        output mem_read_o, mem_write_o, branch_o, retire_o, busy_o, err_o, state_o
    );

    modport slave (
        output run_i, op_i, noop_i, mem_ready_i,
        input  pc_write_o, ir_write_o, alu_op_o, alu_src_o, reg_write_o, mem_to_reg_o,
        input  mem_read_o, mem_write_o, branch_o, retire_o, busy_o, err_o, state_o
    );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decoder; unknown opcodes map to RALU and raise illegal_o.
module ctrl_decode
    import ctrl_fsm_pkg::*;
(
    input  logic [6:0] op_i,
    output cls_e       cls_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o     = ClsRalu;
        illegal_o = 1'b0;
        unique case (op_i)
            OpLoad:  cls_o = ClsLoad;
            OpStore: cls_o = ClsStore;
            OpIalu:  cls_o = ClsIalu;
            OpBeq:   cls_o = ClsBeq;
            OpRalu:  cls_o = ClsRalu;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout.
// Define CTRL_FSM_ILLEGAL_EN to trap unknown opcodes into ERR.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned WAIT_W       = $clog2(MEM_WAIT_MAX + 1)
) (
    input logic         clk_i,
    input logic         rst_i,
    ctrl_fsm_if.master  bus
);

    state_e            stateQ, stateD, endState;
    cls_e              clsQ, clsD, decCls;
    logic [WAIT_W-1:0] cntQ, cntD;
    logic              decIllegal, illegalTrap, memLimit;

    logic       pcWrite, irWrite, aluSrc, regWrite, memToReg;
    logic       memRead, memWrite, branch, retire, busy, err;
    logic [1:0] aluOp;

    ctrl_decode u_decode (
        .op_i      (bus.op_i),
        .cls_o     (decCls),
        .illegal_o (decIllegal)
    );

`ifdef CTRL_FSM_ILLEGAL_EN
    assign illegalTrap = decIllegal;
`else
    // Legacy build: unknown opcodes simply run as RALU.
    assign illegalTrap = 1'b0;
    logic unusedIllegal;
    assign unusedIllegal = decIllegal;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ <= StIdle;
            clsQ   <= ClsRalu;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            clsQ   <= clsD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        clsD     = clsQ;
        cntD     = '0;
        pcWrite  = 1'b0;
        irWrite  = 1'b0;
        aluOp    = AluAdd;
        aluSrc   = 1'b0;
        regWrite = 1'b0;
        memToReg = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        branch   = 1'b0;
        retire   = 1'b0;
        busy     = (stateQ != StIdle);
        err      = 1'b0;
        endState = bus.run_i ? StFetch : StIdle;
        memLimit = (cntQ == WAIT_W'(MEM_WAIT_MAX));

        unique case (stateQ)
            StIdle: begin
                if (bus.run_i) stateD = StFetch;
            end
            StFetch: begin
                memRead = 1'b1;
                if (bus.mem_ready_i) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    stateD  = StDecode;
                end else if (memLimit) begin
                    stateD = StErr;
                end
            end
            StDecode: begin
                clsD = decCls;
                if (bus.noop_i) begin
                    stateD = endState;
                end else if (illegalTrap) begin
                    stateD = StErr;
                end else begin
                    stateD = StExec;
                end
            end
            StExec: begin
                unique case (clsQ)
                    ClsBeq: begin
                        aluOp  = AluBranch;
                        branch = 1'b1;
                        retire = 1'b1;
                        stateD = endState;
                    end
                    ClsRalu: begin
                        aluOp  = AluFunct;
                        stateD = StWb;
                    end
                    default: begin
                        aluOp  = AluAdd;
                        aluSrc = 1'b1;
                        stateD = isMemCls(clsQ) ? StMem : StWb;
                    end
                endcase
            end
            StMem: begin
                memRead  = (clsQ == ClsLoad);
                memWrite = (clsQ != ClsLoad);
                if (bus.mem_ready_i) begin
                    if (clsQ == ClsLoad) begin
                        stateD = StWb;
                    end else begin
                        retire = 1'b1;
                        stateD = endState;
                    end
                end else if (memLimit) begin
                    stateD = StErr;
                end
            end
            StWb: begin
                regWrite = 1'b1;
                memToReg = (clsQ == ClsLoad);
                retire   = 1'b1;
                stateD   = endState;
            end
            StErr: begin
                err = 1'b1;
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        // Count only while parked in a memory state; any entry restarts from zero.
        if ((stateQ == StFetch || stateQ == StMem) && stateD == stateQ) begin
            cntD = cntQ + WAIT_W'(1);
        end

        // Nothing may fire in the cycle a reset is being applied.
        if (rst_i) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            aluOp    = AluAdd;
            aluSrc   = 1'b0;
            regWrite = 1'b0;
            memToReg = 1'b0;
            memRead  = 1'b0;
            memWrite = 1'b0;
            branch   = 1'b0;
            retire   = 1'b0;
            busy     = 1'b0;
            err      = 1'b0;
        end
    end

    assign bus.pc_write_o   = pcWrite;
    assign bus.ir_write_o   = irWrite;
    assign bus.alu_op_o     = aluOp;
    assign bus.alu_src_o    = aluSrc;
    assign bus.reg_write_o  = regWrite;
    assign bus.mem_to_reg_o = memToReg;
    assign bus.mem_read_o   = memRead;
    assign bus.mem_write_o  = memWrite;
    assign bus.branch_o     = branch;
    assign bus.retire_o     = retire;
    assign bus.busy_o       = busy;
    assign bus.err_o        = err;
    assign bus.state_o      = stateQ;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed-vector bench for ctrl_fsm; each cycle's full output word is checked.
module tb_ctrl_fsm;
    import ctrl_fsm_pkg::*;

    // Output word: {state[15:13], pcw, irw, aluop[10:9], asrc, rw, m2r, mr, mw, br, ret, busy, err}
    localparam logic [15:0] ERRB   = 16'h0001;
    localparam logic [15:0] BUSY   = 16'h0002;
    localparam logic [15:0] RET    = 16'h0004;
    localparam logic [15:0] BR     = 16'h0008;
    localparam logic [15:0] MW     = 16'h0010;
    localparam logic [15:0] MR     = 16'h0020;
    localparam logic [15:0] M2R    = 16'h0040;
    localparam logic [15:0] RW     = 16'h0080;
    localparam logic [15:0] ASRC   = 16'h0100;
    localparam logic [15:0] AOP_BR = 16'h0200;
    localparam logic [15:0] AOP_FN = 16'h0400;
    localparam logic [15:0] IRW    = 16'h0800;
    localparam logic [15:0] PCW    = 16'h1000;

    localparam logic [15:0] S_IDLE  = 16'h0000;
    localparam logic [15:0] S_FETCH = 16'h2000;
    localparam logic [15:0] S_DEC   = 16'h4000;
    localparam logic [15:0] S_EXEC  = 16'h6000;
    localparam logic [15:0] S_MEM   = 16'h8000;
    localparam logic [15:0] S_WB    = 16'hA000;
    localparam logic [15:0] S_ERR   = 16'hC000;

    localparam logic [15:0] F_RDY = S_FETCH | PCW | IRW | MR | BUSY;
    localparam logic [15:0] DEC   = S_DEC | BUSY;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;
    logic [6:0] opBad = 7'b1111111;

    ctrl_fsm_if bus ();

    ctrl_fsm #(
        .MEM_WAIT_MAX (15)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obsWord();
        return {bus.state_o, bus.pc_write_o, bus.ir_write_o, bus.alu_op_o, bus.alu_src_o,
                bus.reg_write_o, bus.mem_to_reg_o, bus.mem_read_o, bus.mem_write_o,
                bus.branch_o, bus.retire_o, bus.busy_o, bus.err_o};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle, compare at the falling edge, then advance past the next edge.
    task automatic step(input string tag, input logic run, input logic [6:0] op,
                        input logic noop, input logic rdy, input logic [15:0] exp);
        bus.run_i       = run;
        bus.op_i        = op;
        bus.noop_i      = noop;
        bus.mem_ready_i = rdy;
        @(negedge clk);
        check(tag, obsWord(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.run_i       = 1'b0;
        bus.op_i        = '0;
        bus.noop_i      = 1'b0;
        bus.mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset_hold", 1'b1, OpRalu, 1'b0, 1'b1, S_IDLE);
        rst = 1'b0;

        // RALU, zero wait
        step("idle_run0", 1'b0, OpRalu, 1'b0, 1'b1, S_IDLE);
        step("idle_go",   1'b1, OpRalu, 1'b0, 1'b1, S_IDLE);
        step("r_fetch",   1'b1, OpRalu, 1'b0, 1'b1, F_RDY);
        step("r_dec",     1'b1, OpRalu, 1'b0, 1'b1, DEC);
        step("r_exec",    1'b1, OpLoad, 1'b0, 1'b1, S_EXEC | AOP_FN | BUSY);
        step("r_wb",      1'b1, OpLoad, 1'b0, 1'b1, S_WB | RW | RET | BUSY);

        // LOAD with three memory wait cycles
        step("l_fetch", 1'b1, OpBeq,  1'b0, 1'b1, F_RDY);
        step("l_dec",   1'b1, OpLoad, 1'b0, 1'b1, DEC);
        step("l_exec",  1'b1, OpBeq,  1'b0, 1'b0, S_EXEC | ASRC | BUSY);
        for (int i = 0; i < 3; i++) step("l_mem_wait", 1'b1, OpBeq, 1'b0, 1'b0, S_MEM | MR | BUSY);
        step("l_mem_rdy", 1'b1, OpBeq, 1'b0, 1'b1, S_MEM | MR | BUSY);
        step("l_wb",      1'b1, OpBeq, 1'b0, 1'b1, S_WB | RW | M2R | RET | BUSY);

        // BEQ after one fetch wait, run dropped at the end
        step("b_fetch_wait", 1'b1, OpRalu, 1'b0, 1'b0, S_FETCH | MR | BUSY);
        step("b_fetch",      1'b1, OpRalu, 1'b0, 1'b1, F_RDY);
        step("b_dec",        1'b1, OpBeq,  1'b0, 1'b1, DEC);
        step("b_exec",       1'b0, OpRalu, 1'b0, 1'b1, S_EXEC | AOP_BR | BR | RET | BUSY);
        step("b_idle",       1'b0, OpRalu, 1'b0, 1'b1, S_IDLE);

        // Bubble, then STORE with run dropped mid-instruction
        step("n_go",     1'b1, OpRalu,  1'b0, 1'b0, S_IDLE);
        step("n_fetch",  1'b1, OpRalu,  1'b0, 1'b1, F_RDY);
        step("n_dec",    1'b1, OpLoad,  1'b1, 1'b1, DEC);
        step("n_fetch2", 1'b1, OpRalu,  1'b0, 1'b1, F_RDY);
        step("s_dec",    1'b0, OpStore, 1'b0, 1'b1, DEC);
        step("s_exec",   1'b0, OpRalu,  1'b0, 1'b1, S_EXEC | ASRC | BUSY);
        step("s_mem",    1'b0, OpRalu,  1'b0, 1'b1, S_MEM | MW | RET | BUSY);
        step("s_idle",   1'b0, OpRalu,  1'b0, 1'b0, S_IDLE);

        // STORE whose ready arrives exactly at the wait limit
        step("t_go",    1'b1, OpStore, 1'b0, 1'b0, S_IDLE);
        step("t_fetch", 1'b1, OpStore, 1'b0, 1'b1, F_RDY);
        step("t_dec",   1'b1, OpStore, 1'b0, 1'b1, DEC);
        step("t_exec",  1'b1, OpStore, 1'b0, 1'b0, S_EXEC | ASRC | BUSY);
        for (int i = 0; i < 15; i++) step("t_mem_wait", 1'b1, OpStore, 1'b0, 1'b0, S_MEM | MW | BUSY);
        step("t_mem_limit", 1'b1, OpStore, 1'b0, 1'b1, S_MEM | MW | RET | BUSY);
        step("t_next",      1'b1, OpRalu,  1'b0, 1'b1, F_RDY);

        // Reset in WB suppresses the register write
        step("w_dec",  1'b1, OpRalu, 1'b0, 1'b1, DEC);
        step("w_exec", 1'b1, OpRalu, 1'b0, 1'b1, S_EXEC | AOP_FN | BUSY);
        rst = 1'b1;
        step("w_rst",  1'b1, OpRalu, 1'b0, 1'b1, S_WB);
        rst = 1'b0;
        step("w_idle", 1'b1, OpRalu, 1'b0, 1'b1, S_IDLE);

        // LOAD that never gets ready: timeout into sticky ERR
        step("e_fetch", 1'b1, OpLoad, 1'b0, 1'b1, F_RDY);
        step("e_dec",   1'b1, OpLoad, 1'b0, 1'b1, DEC);
        step("e_exec",  1'b1, OpLoad, 1'b0, 1'b0, S_EXEC | ASRC | BUSY);
        for (int i = 0; i < 16; i++) step("e_mem_wait", 1'b1, OpLoad, 1'b0, 1'b0, S_MEM | MR | BUSY);
        step("e_err0", 1'b1, OpLoad, 1'b0, 1'b1, S_ERR | BUSY | ERRB);
        step("e_err1", 1'b0, OpRalu, 1'b1, 1'b1, S_ERR | BUSY | ERRB);
        step("e_err2", 1'b1, OpBeq,  1'b0, 1'b0, S_ERR | BUSY | ERRB);
        rst = 1'b1;
        step("e_rst",  1'b1, OpRalu, 1'b0, 1'b1, S_ERR);
        rst = 1'b0;
        step("e_idle", 1'b1, OpRalu, 1'b0, 1'b1, S_IDLE);

        // Unknown opcode
        step("x_fetch", 1'b1, opBad, 1'b0, 1'b1, F_RDY);
        step("x_dec",   1'b1, opBad, 1'b0, 1'b1, DEC);
`ifdef CTRL_FSM_ILLEGAL_EN
        step("x_err",   1'b1, opBad, 1'b0, 1'b1, S_ERR | BUSY | ERRB);
        step("x_err2",  1'b1, opBad, 1'b0, 1'b1, S_ERR | BUSY | ERRB);
`else
        step("x_exec",  1'b1, opBad, 1'b0, 1'b1, S_EXEC | AOP_FN | BUSY);
        step("x_wb",    1'b1, opBad, 1'b0, 1'b1, S_WB | RW | RET | BUSY);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle main control unit for the RISC-V datapath, replacing the single-cycle combinational opcode decoder. It sequences each instruction through the FETCH, DECODE, EXEC, MEM and WB states over a shared memory port with a ready handshake. Per state, it drives the existing control-signal set: ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite and Branch, plus the PC and IR write enables. It sits between the instruction register / memory interface and the datapath register file and ALU.

## Interface
Parameters:
- MEM_WAIT_MAX, 15, maximum cycles a FETCH or MEM access waits for mem_ready_i before a timeout error.
- WAIT_W, $clog2(MEM_WAIT_MAX+1), wait-counter width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- run_i  in  1  level; while high the FSM keeps fetching instructions.
- op_i  in  7  opcode field from the instruction register; sampled in DECODE.
- noop_i  in  1  bubble request; sampled in DECODE.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- pc_write_o  out  1  PC update enable.
- ir_write_o  out  1  IR load enable.
- alu_op_o  out  2  ALUOp: 00 add, 01 branch compare, 10 funct-decoded.
- alu_src_o  out  1  1 = immediate operand.
- reg_write_o  out  1  register-file write enable.
- mem_to_reg_o  out  1  1 = write-back from memory.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- branch_o  out  1  branch-resolve enable.
- retire_o  out  1  one-cycle pulse per completed instruction.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky memory-timeout flag.
- state_o  out  3  current state encoding (debug).

## Operation
- Opcode classes:
  - LOAD 0000011.
  - STORE 0100011.
  - IALU 0010011 (addi/srai).
  - BEQ 1100011.
  - RALU 0110011.
- The class is latched in DECODE and held until the instruction ends.
- IDLE: all outputs 0. Go to FETCH when run_i=1.
- FETCH: mem_read_o=1.
  - On mem_ready_i, pulse ir_write_o and pc_write_o and go to DECODE.
- DECODE: latch class.
  - If noop_i=1, the instruction is a bubble: go to FETCH with no writes and no retire.
  - Otherwise go to EXEC.
- EXEC:
  - LOAD/STORE/IALU: alu_op 00, alu_src 1.
  - BEQ: alu_op 01, branch_o 1, retire_o 1, then go to FETCH.
  - RALU: alu_op 10, alu_src 0.
  - LOAD/STORE go to MEM; IALU/RALU go to WB.
- MEM: LOAD holds mem_read_o=1 and STORE holds mem_write_o=1 until mem_ready_i.
  - On ready, LOAD goes to WB; STORE pulses retire_o and goes to FETCH.
- WB: reg_write_o=1; mem_to_reg_o=1 only for LOAD; retire_o=1; go to FETCH.
- ERR: all outputs 0 except err_o=1 and busy_o=1. Exit only by reset.
- End of instruction: at each point where the FSM would go to FETCH, it goes to IDLE instead if run_i=0. Deasserting run_i never aborts an instruction in flight.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle without ready.
  - If the counter reaches MEM_WAIT_MAX with mem_ready_i=0, go to ERR.
  - mem_ready_i in the same cycle as the limit wins: normal transition.
- Control outputs are Moore: a function of state and latched class. ir_write_o and pc_write_o are qualified by mem_ready_i.

## Timing
- Reset: state IDLE, all outputs 0, counter 0, latched class RALU.
- Reset asserted mid-instruction: IDLE at the next edge; no write-enable is asserted in that cycle.
- Cycles per instruction with zero memory wait:
  - BEQ 3.
  - RALU / IALU 4.
  - STORE 4.
  - LOAD 5.
  - Bubble 2.
- Each memory wait cycle adds one cycle.
- retire_o is high for exactly one cycle per instruction.
- Changes on op_i and noop_i outside DECODE are ignored.

## Configuration
- CTRL_FSM_ILLEGAL_EN defined:
  - An opcode matching no class sends DECODE to ERR.
  - err_o is set and no write-enable is asserted.
- Not defined: unknown opcodes decode as RALU (legacy behaviour).

## Structure
- ctrl_fsm_pkg holds:
  - State enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
  - Opcode constants.
  - ALUOp encodings.
  - Instruction-class enum.
- One combinational sub-module, ctrl_decode, maps op_i to class plus an illegal flag. The FSM and wait counter stay in ctrl_fsm.

## Test plan
- Reset then run_i=1, op_i=0110011, mem_ready_i=1 -> states FETCH, DECODE, EXEC (alu_op 10), WB (reg_write 1); retire at cycle 4.
- op_i=0000011 with mem_ready_i low for 3 MEM cycles -> mem_read held 3 cycles; WB with mem_to_reg 1; total 8 cycles.
- op_i=1100011 -> branch_o=1 and alu_op=01 in EXEC; retire after 3 cycles; reg_write never high.
- noop_i=1 in DECODE -> back to FETCH after 2 cycles; no retire_o, no write-enables.
- mem_ready_i held 0 in MEM -> ERR after 15 wait cycles, err_o sticky until rst_i. Ready on the 15th wait cycle instead -> normal completion.
- op_i=1111111 -> with CTRL_FSM_ILLEGAL_EN: ERR and err_o=1. Without it: RALU, alu_op 10.
